// File: rtl/ex_stage_unit_if.sv
// Interface bundling the ID/EX inputs, forwarding data and EX/MEM outputs of ex_stage_unit.
// The pipeline side uses the master modport and the execute stage uses the slave modport.
interface ex_stage_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [3:0]        id_alu_op;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [1:0]        for_a;
    logic [1:0]        for_b;
    logic [DATA_W-1:0] mem_fwd_data;
    logic [DATA_W-1:0] wb_fwd_data;
    logic              flush;
    logic              ex_busy;
    logic              exmem_valid;
    logic              exmem_reg_write;
    logic              exmem_mem_read;
    logic              exmem_mem_write;
    logic [DATA_W-1:0] exmem_alu_result;
    logic [DATA_W-1:0] exmem_store_data;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_ovf_trap;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_use_imm, id_alu_op, id_rd,
               id_reg_write, id_mem_read, id_mem_write, for_a, for_b,
               mem_fwd_data, wb_fwd_data, flush,
        input  ex_busy, exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write,
               exmem_alu_result, exmem_store_data, exmem_rd, exmem_ovf_trap
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_use_imm, id_alu_op, id_rd,
               id_reg_write, id_mem_read, id_mem_write, for_a, for_b,
               mem_fwd_data, wb_fwd_data, flush,
        output ex_busy, exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write,
               exmem_alu_result, exmem_store_data, exmem_rd, exmem_ovf_trap
    );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, iterative shift-add multiplier and the EX/MEM register.
// Optional feature macro: EX_OVF_TRAP_EN (trap signed ADD/SUB overflow instead of writing back).
module ex_stage_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic             clk,
    input logic             rst,
    ex_stage_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;

    mul_state_e        state;
    mul_state_e        state_nxt;
    logic [CNT_W-1:0]  mul_count;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_acc;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_result;
    logic              mul_start;
    logic              load_bubble;
    logic              load_product;
    logic              ovf_trap_now;

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_v,
        input logic [DATA_W-1:0] mem_v,
        input logic [DATA_W-1:0] wb_v
    );
        case (sel)
            2'b10:   return mem_v;
            2'b01:   return wb_v;
            default: return reg_v;
        endcase
    endfunction

    always_comb begin
        op_a  = fwd_mux(bus.for_a, bus.id_rs_data, bus.mem_fwd_data, bus.wb_fwd_data);
        fwd_b = fwd_mux(bus.for_b, bus.id_rt_data, bus.mem_fwd_data, bus.wb_fwd_data);
        op_b  = bus.id_use_imm ? bus.id_imm : fwd_b;
        shamt = op_b[4:0];
    end

    // Single-cycle ALU; MUL (op C) is produced by the multiplier, so it falls to 0 here
    always_comb begin
        alu_result = '0;
        case (bus.id_alu_op)
            4'h0: alu_result = op_a + op_b;
            4'h1: alu_result = op_a - op_b;
            4'h2: alu_result = op_a & op_b;
            4'h3: alu_result = op_a | op_b;
            4'h4: alu_result = op_a ^ op_b;
            4'h5: alu_result = ~(op_a | op_b);
            4'h6: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'h7: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            4'h8: alu_result = op_a << shamt;
            4'h9: alu_result = op_a >> shamt;
            4'hA: alu_result = $signed(op_a) >>> shamt;
            4'hB: alu_result = op_b << 16;
            default: alu_result = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    logic add_ovf;
    logic sub_ovf;

    always_comb begin
        add_ovf      = (op_a[MSB] == op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
        sub_ovf      = (op_a[MSB] != op_b[MSB]) && (alu_result[MSB] != op_a[MSB]);
        ovf_trap_now = !load_product &&
                       (((bus.id_alu_op == 4'h0) && add_ovf) || ((bus.id_alu_op == 4'h1) && sub_ovf));
    end
`else
    always_comb begin
        ovf_trap_now = 1'b0;
    end
`endif

    assign mul_start = bus.id_valid && (bus.id_alu_op == 4'hC) && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) state_nxt = RUN;
                RUN:     if (mul_count == CNT_W'(DATA_W - 1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stall covers the MUL start cycle and every RUN step, never the product-load cycle
    always_comb begin
        bus.ex_busy  = !rst && !bus.flush && (((state == IDLE) && mul_start) || (state == RUN));
        load_product = (state == DONE);
        load_bubble  = bus.flush || !bus.id_valid || (state == RUN) ||
                       ((state == IDLE) && mul_start);
    end

    // Operands are captured at start because the forwarding sources move on during the stall
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_acc   <= '0;
            mul_count <= '0;
        end else if (state == IDLE) begin
            if (mul_start) begin
                mul_a     <= op_a;
                mul_b     <= op_b;
                mul_acc   <= '0;
                mul_count <= '0;
            end
        end else if (state == RUN) begin
            if (mul_b[0]) mul_acc <= mul_acc + mul_a;
            mul_a     <= mul_a << 1;
            mul_b     <= mul_b >> 1;
            mul_count <= mul_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.exmem_valid      <= 1'b0;
            bus.exmem_reg_write  <= 1'b0;
            bus.exmem_mem_read   <= 1'b0;
            bus.exmem_mem_write  <= 1'b0;
            bus.exmem_alu_result <= '0;
            bus.exmem_store_data <= '0;
            bus.exmem_rd         <= '0;
            bus.exmem_ovf_trap   <= 1'b0;
        end else begin
            bus.exmem_alu_result <= load_product ? mul_acc : alu_result;
            bus.exmem_store_data <= fwd_b;
            bus.exmem_rd         <= bus.id_rd;
            if (load_bubble) begin
                bus.exmem_valid     <= 1'b0;
                bus.exmem_reg_write <= 1'b0;
                bus.exmem_mem_read  <= 1'b0;
                bus.exmem_mem_write <= 1'b0;
                bus.exmem_ovf_trap  <= 1'b0;
            end else begin
                bus.exmem_valid     <= 1'b1;
                bus.exmem_reg_write <= bus.id_reg_write && !ovf_trap_now;
                bus.exmem_mem_read  <= bus.id_mem_read;
                bus.exmem_mem_write <= bus.id_mem_write;
                bus.exmem_ovf_trap  <= ovf_trap_now;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed testbench for ex_stage_unit with a cycle-level reference model of the execute stage.
// Build with +define+EX_OVF_TRAP_EN to check the overflow-trap variant.
module tb_ex_stage_unit;

    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_stage_unit_if #(.DATA_W(DW), .REG_AW(5)) bus ();

    ex_stage_unit #(.DATA_W(DW), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: expected EX/MEM contents plus remaining MUL occupancy
    logic        model_ready;
    logic        exp_zero;
    logic        exp_valid;
    logic        exp_rw;
    logic        exp_mr;
    logic        exp_mw;
    logic        exp_trap;
    logic [31:0] exp_result;
    logic [31:0] exp_store;
    logic [4:0]  exp_rd;
    int          mul_left;
    logic [31:0] mul_a_m;
    logic [31:0] mul_b_m;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'b10) return m;
        if (sel == 2'b01) return w;
        return r;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return a << sh;
            4'h9: return a >> sh;
            4'hA: return $signed(a) >>> sh;
            4'hB: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed_ovf(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'h0)      r = sa + sb;
        else if (op == 4'h1) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic model_busy();
        if (rst || bus.flush) return 1'b0;
        if (mul_left > 1) return 1'b1;
        return (mul_left == 0) && bus.id_valid && (bus.id_alu_op == 4'hC);
    endfunction

    task automatic modelBubble();
        exp_valid = 1'b0;
        exp_rw    = 1'b0;
        exp_mr    = 1'b0;
        exp_mw    = 1'b0;
        exp_trap  = 1'b0;
    endtask

    initial begin
        model_ready = 1'b0;
        mul_left    = 0;
    end

    // Model advances on each rising edge from the inputs presented during that cycle
    always @(posedge clk) begin
        logic [31:0] a;
        logic [31:0] fb;
        logic [31:0] b;
        logic        trap;
        a  = pick(bus.for_a, bus.id_rs_data, bus.mem_fwd_data, bus.wb_fwd_data);
        fb = pick(bus.for_b, bus.id_rt_data, bus.mem_fwd_data, bus.wb_fwd_data);
        b  = bus.id_use_imm ? bus.id_imm : fb;
        if (rst) begin
            modelBubble();
            exp_result  = 32'd0;
            exp_store   = 32'd0;
            exp_rd      = 5'd0;
            exp_zero    = 1'b1;
            mul_left    = 0;
            model_ready = 1'b1;
        end else begin
            exp_zero = 1'b0;
            if (bus.flush) begin
                modelBubble();
                mul_left = 0;
            end else if (mul_left > 1) begin
                modelBubble();
                mul_left = mul_left - 1;
            end else if (mul_left == 1 || (bus.id_valid && bus.id_alu_op != 4'hC)) begin
                trap = 1'b0;
`ifdef EX_OVF_TRAP_EN
                if (mul_left == 0) trap = signed_ovf(bus.id_alu_op, a, b);
`endif
                exp_valid  = 1'b1;
                exp_rw     = bus.id_reg_write && !trap;
                exp_mr     = bus.id_mem_read;
                exp_mw     = bus.id_mem_write;
                exp_trap   = trap;
                exp_result = (mul_left == 1) ? mul_a_m * mul_b_m : alu_model(bus.id_alu_op, a, b);
                exp_store  = fb;
                exp_rd     = bus.id_rd;
                mul_left   = 0;
            end else if (bus.id_valid) begin
                modelBubble();
                mul_a_m  = a;
                mul_b_m  = b;
                mul_left = DW + 1;
            end else begin
                modelBubble();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single compare process: outputs against the model every cycle, mid-period
    always @(negedge clk) begin
        #2;
        if (model_ready) begin
            checkOutput("ex_busy", 32'(bus.ex_busy), 32'(model_busy()));
            checkOutput("exmem_valid", 32'(bus.exmem_valid), 32'(exp_valid));
            checkOutput("exmem_reg_write", 32'(bus.exmem_reg_write), 32'(exp_rw));
            checkOutput("exmem_mem_read", 32'(bus.exmem_mem_read), 32'(exp_mr));
            checkOutput("exmem_mem_write", 32'(bus.exmem_mem_write), 32'(exp_mw));
            checkOutput("exmem_ovf_trap", 32'(bus.exmem_ovf_trap), 32'(exp_trap));
            if (exp_valid || exp_zero) begin
                checkOutput("exmem_alu_result", bus.exmem_alu_result, exp_result);
                checkOutput("exmem_store_data", bus.exmem_store_data, exp_store);
                checkOutput("exmem_rd", 32'(bus.exmem_rd), 32'(exp_rd));
            end
        end
    end

    task automatic applyStimulus(input logic valid, input logic [3:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] memf, input logic [31:0] wbf,
                                 input logic [4:0] rd);
        @(negedge clk);
        bus.id_valid     = valid;
        bus.id_alu_op    = op;
        bus.id_rs_data   = rs;
        bus.id_rt_data   = rt;
        bus.for_a        = fa;
        bus.for_b        = fb;
        bus.mem_fwd_data = memf;
        bus.wb_fwd_data  = wbf;
        bus.id_rd        = rd;
        bus.id_imm       = 32'd0;
        bus.id_use_imm   = 1'b0;
        bus.id_reg_write = 1'b1;
        bus.id_mem_read  = 1'b0;
        bus.id_mem_write = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic pinResult(input string name, input logic [31:0] exp);
        @(posedge clk);
        #3;
        checkOutput(name, bus.exmem_alu_result, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cnt;
        int bubbles;
        logic done;

        n_checks = 0;
        n_fail   = 0;
        vecs = '{
            '{4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
            '{4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
            '{4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
            '{4'h5, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00},
            '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'h8, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030},
            '{4'h9, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
            '{4'hA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
            '{4'hB, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000},
            '{4'hD, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000},
            '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{4'h0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
            '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF}
        };

        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_alu_op = 4'h0; bus.id_rs_data = '0; bus.id_rt_data = '0;
        bus.id_imm = '0; bus.id_use_imm = 1'b0; bus.id_rd = '0; bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0; bus.for_a = 2'b00; bus.for_b = 2'b00;
        bus.mem_fwd_data = '0; bus.wb_fwd_data = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_valid", 32'(bus.exmem_valid), 32'd0);
        checkOutput("reset_result", bus.exmem_alu_result, 32'd0);
        checkOutput("reset_busy", 32'(bus.ex_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] forwarding and basic ALU");
        applyStimulus(1'b1, 4'h0, 32'd100, 32'd3, 2'b10, 2'b00, 32'd5, 32'd0, 5'd7);
        bus.id_mem_write = 1'b1;
        pinResult("add_fwd_mem", 32'd8);
        checkOutput("add_valid", 32'(bus.exmem_valid), 32'd1);
        checkOutput("add_rd", 32'(bus.exmem_rd), 32'd7);
        checkOutput("add_mem_write", 32'(bus.exmem_mem_write), 32'd1);

        applyStimulus(1'b1, 4'h1, 32'd9, 32'd0, 2'b00, 2'b01, 32'd0, 32'd2, 5'd3);
        pinResult("sub_fwd_wb", 32'd7);
        applyStimulus(1'b1, 4'h1, 32'd9, 32'd4, 2'b00, 2'b11, 32'd0, 32'd2, 5'd3);
        bus.id_mem_read = 1'b1;
        pinResult("sub_fwd_11", 32'd5);
        checkOutput("sub_mem_read", 32'(bus.exmem_mem_read), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 2'b00, 2'b00, 32'd0, 32'd0, 5'(i));
            pinResult($sformatf("alu_vec%0d", i), vecs[i].r);
        end

        applyStimulus(1'b1, 4'h0, 32'd100, 32'd0, 2'b00, 2'b10, 32'h0000_00AB, 32'd0, 5'd9);
        bus.id_use_imm   = 1'b1;
        bus.id_imm       = 32'd4;
        bus.id_reg_write = 1'b0;
        bus.id_mem_write = 1'b1;
        pinResult("store_addr", 32'd104);
        checkOutput("store_data", bus.exmem_store_data, 32'h0000_00AB);

        applyStimulus(1'b0, 4'h0, 32'd1, 32'd1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4);
        @(posedge clk);
        #3;
        checkOutput("bubble_valid", 32'(bus.exmem_valid), 32'd0);
        checkOutput("bubble_reg_write", 32'(bus.exmem_reg_write), 32'd0);

        $display("[TB] multiplier 7*6 with moving forward source");
        applyStimulus(1'b1, 4'hC, 32'd0, 32'd6, 2'b10, 2'b00, 32'd7, 32'd0, 5'd12);
        busy_cnt = 0;
        bubbles  = 0;
        done     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (i > 0 && !bus.exmem_valid) bubbles++;
            if (!bus.ex_busy) begin
                done = 1'b1;
                break;
            end
            busy_cnt++;
            @(negedge clk);
            bus.mem_fwd_data = 32'd99;
        end
        checkOutput("mul_finished", 32'(done), 32'd1);
        checkOutput("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        checkOutput("mul_bubbles", 32'(bubbles), 32'd33);
        pinResult("mul_product", 32'd42);
        checkOutput("mul_valid", 32'(bus.exmem_valid), 32'd1);
        checkOutput("mul_rd", 32'(bus.exmem_rd), 32'd12);

        $display("[TB] multiplier aborted by flush");
        applyStimulus(1'b1, 4'hC, 32'd5, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 5'd13);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_busy_drop", 32'(bus.ex_busy), 32'd0);
        @(posedge clk);
        #3;
        checkOutput("flush_bubble", 32'(bus.exmem_valid), 32'd0);
        applyStimulus(1'b1, 4'h0, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0, 32'd0, 5'd14);
        #1;
        checkOutput("flush_idle_busy", 32'(bus.ex_busy), 32'd0);
        pinResult("after_flush_add", 32'd7);

        $display("[TB] reset during multiply");
        applyStimulus(1'b1, 4'hC, 32'd9, 32'd9, 2'b00, 2'b00, 32'd0, 32'd0, 5'd15);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.id_valid = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("rst_mid_valid", 32'(bus.exmem_valid), 32'd0);
        checkOutput("rst_mid_store", bus.exmem_store_data, 32'd0);
        checkOutput("rst_mid_rd", 32'(bus.exmem_rd), 32'd0);
        checkOutput("rst_mid_busy", 32'(bus.ex_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 4'h0, 32'd1, 32'd1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd1);
        #1;
        checkOutput("rst_after_busy", 32'(bus.ex_busy), 32'd0);
        pinResult("rst_after_add", 32'd2);

        $display("[TB] signed overflow");
        applyStimulus(1'b1, 4'h0, 32'h7FFF_FFFF, 32'd1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd20);
        pinResult("ovf_add_result", 32'h8000_0000);
`ifdef EX_OVF_TRAP_EN
        checkOutput("ovf_trap", 32'(bus.exmem_ovf_trap), 32'd1);
        checkOutput("ovf_reg_write", 32'(bus.exmem_reg_write), 32'd0);
`else
        checkOutput("ovf_trap", 32'(bus.exmem_ovf_trap), 32'd0);
        checkOutput("ovf_reg_write", 32'(bus.exmem_reg_write), 32'd1);
`endif
        applyStimulus(1'b1, 4'h1, 32'h8000_0000, 32'd1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd21);
        pinResult("ovf_sub_result", 32'h7FFF_FFFF);

        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
        repeat (2) @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
